// File: rtl/qam16_symbol_mapper.sv
// 16-QAM Gray mapper with a linear inter-symbol ramp and an idle return-to-zero.
// Optional statistics counters are built only when MAPPER_STATS_EN is defined.
module qam16_symbol_mapper #(
  parameter int AMP_WIDTH    = 16,
  parameter int LEVEL_A      = 8192,
  parameter int RAMP_SHIFT   = 4,
  parameter int IDLE_TIMEOUT = 8500000
) (
  input  logic                        ipClk,
  input  logic                        ipReset,
  input  logic [3:0]                  ipQAMBlock,
  input  logic                        ipQAMBlockValid,
  output logic signed [AMP_WIDTH-1:0] opI,
  output logic signed [AMP_WIDTH-1:0] opQ,
  output logic                        opRamping,
  output logic                        opIdle,
  output logic [31:0]                 opSymbolCount,
  output logic [15:0]                 opOverrunCount
);

  localparam int SW = AMP_WIDTH + 1;
  localparam int TW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic signed [AMP_WIDTH-1:0] LVL_P1 = AMP_WIDTH'(LEVEL_A);
  localparam logic signed [AMP_WIDTH-1:0] LVL_M1 = AMP_WIDTH'(-LEVEL_A);
  localparam logic signed [AMP_WIDTH-1:0] LVL_P3 = AMP_WIDTH'(3 * LEVEL_A);
  localparam logic signed [AMP_WIDTH-1:0] LVL_M3 = AMP_WIDTH'(-3 * LEVEL_A);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic signed [AMP_WIDTH-1:0] f_gray_level(input logic [1:0] i_bits);
    logic signed [AMP_WIDTH-1:0] v_lvl;
    case (i_bits)
      2'b00:   v_lvl = LVL_M3;
      2'b01:   v_lvl = LVL_M1;
      2'b11:   v_lvl = LVL_P1;
      default: v_lvl = LVL_P3;
    endcase
    return v_lvl;
  endfunction

  state_t                      r_state;
  logic signed [AMP_WIDTH-1:0] r_i;
  logic signed [AMP_WIDTH-1:0] r_q;
  logic signed [AMP_WIDTH-1:0] r_tgt_i;
  logic signed [AMP_WIDTH-1:0] r_tgt_q;
  logic signed [AMP_WIDTH-1:0] r_step_i;
  logic signed [AMP_WIDTH-1:0] r_step_q;
  logic [RAMP_SHIFT-1:0]       r_cnt;
  logic [TW-1:0]               r_timer;
  logic                        r_to_idle;
  logic                        r_ramping;
  logic                        r_idle;

  state_t                      w_state_next;
  logic signed [AMP_WIDTH-1:0] w_i_next;
  logic signed [AMP_WIDTH-1:0] w_q_next;
  logic signed [AMP_WIDTH-1:0] w_tgt_i_next;
  logic signed [AMP_WIDTH-1:0] w_tgt_q_next;
  logic signed [AMP_WIDTH-1:0] w_step_i_next;
  logic signed [AMP_WIDTH-1:0] w_step_q_next;
  logic [RAMP_SHIFT-1:0]       w_cnt_next;
  logic [TW-1:0]               w_timer_next;
  logic                        w_to_idle_next;

  logic                        w_timeout;
  logic                        w_start;
  logic signed [AMP_WIDTH-1:0] w_new_tgt_i;
  logic signed [AMP_WIDTH-1:0] w_new_tgt_q;
  logic signed [SW-1:0]        w_diff_i;
  logic signed [SW-1:0]        w_diff_q;
  logic signed [AMP_WIDTH-1:0] w_new_step_i;
  logic signed [AMP_WIDTH-1:0] w_new_step_q;
  logic signed [AMP_WIDTH-1:0] w_step_sel_i;
  logic signed [AMP_WIDTH-1:0] w_step_sel_q;
  logic signed [AMP_WIDTH-1:0] w_sum_i;
  logic signed [AMP_WIDTH-1:0] w_sum_q;

  assign w_timeout = (r_state == S_HOLD) && (r_timer == TW'(IDLE_TIMEOUT - 1));
  assign w_start   = ipQAMBlockValid || w_timeout;

  // An idle timeout uses the same ramp machinery with a target of zero.
  assign w_new_tgt_i = ipQAMBlockValid ? f_gray_level(ipQAMBlock[1:0]) : '0;
  assign w_new_tgt_q = ipQAMBlockValid ? f_gray_level(ipQAMBlock[3:2]) : '0;

  assign w_diff_i = {w_new_tgt_i[AMP_WIDTH-1], w_new_tgt_i} - {r_i[AMP_WIDTH-1], r_i};
  assign w_diff_q = {w_new_tgt_q[AMP_WIDTH-1], w_new_tgt_q} - {r_q[AMP_WIDTH-1], r_q};

  // The shifted difference always fits back into AMP_WIDTH bits.
  assign w_new_step_i = AMP_WIDTH'(w_diff_i >>> RAMP_SHIFT);
  assign w_new_step_q = AMP_WIDTH'(w_diff_q >>> RAMP_SHIFT);

  // The first ramp step is applied on the accepting edge itself.
  assign w_step_sel_i = w_start ? w_new_step_i : r_step_i;
  assign w_step_sel_q = w_start ? w_new_step_q : r_step_q;
  assign w_sum_i      = r_i + w_step_sel_i;
  assign w_sum_q      = r_q + w_step_sel_q;

  always_comb begin
    w_state_next   = r_state;
    w_i_next       = r_i;
    w_q_next       = r_q;
    w_tgt_i_next   = r_tgt_i;
    w_tgt_q_next   = r_tgt_q;
    w_step_i_next  = r_step_i;
    w_step_q_next  = r_step_q;
    w_cnt_next     = r_cnt;
    w_timer_next   = r_timer;
    w_to_idle_next = r_to_idle;

    if (w_start) begin
      w_state_next   = S_RAMP;
      w_tgt_i_next   = w_new_tgt_i;
      w_tgt_q_next   = w_new_tgt_q;
      w_step_i_next  = w_new_step_i;
      w_step_q_next  = w_new_step_q;
      w_cnt_next     = '1;
      w_i_next       = w_sum_i;
      w_q_next       = w_sum_q;
      w_timer_next   = '0;
      w_to_idle_next = !ipQAMBlockValid;
    end else begin
      case (r_state)
        S_RAMP: begin
          if (r_cnt == '0) begin
            w_state_next   = r_to_idle ? S_IDLE : S_HOLD;
            w_to_idle_next = 1'b0;
            w_timer_next   = '0;
          end else if (r_cnt == RAMP_SHIFT'(1)) begin
            // Final step lands exactly on target, absorbing truncation error.
            w_i_next   = r_tgt_i;
            w_q_next   = r_tgt_q;
            w_cnt_next = '0;
          end else begin
            w_i_next   = w_sum_i;
            w_q_next   = w_sum_q;
            w_cnt_next = r_cnt - RAMP_SHIFT'(1);
          end
        end
        S_HOLD: begin
          w_timer_next = r_timer + TW'(1);
        end
        default: begin
          w_timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_q       <= '0;
      r_tgt_i   <= '0;
      r_tgt_q   <= '0;
      r_step_i  <= '0;
      r_step_q  <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_to_idle <= 1'b0;
      r_ramping <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_i       <= w_i_next;
      r_q       <= w_q_next;
      r_tgt_i   <= w_tgt_i_next;
      r_tgt_q   <= w_tgt_q_next;
      r_step_i  <= w_step_i_next;
      r_step_q  <= w_step_q_next;
      r_cnt     <= w_cnt_next;
      r_timer   <= w_timer_next;
      r_to_idle <= w_to_idle_next;
      r_ramping <= (w_state_next == S_RAMP);
      r_idle    <= (w_state_next == S_IDLE);
    end
  end

  assign opI       = r_i;
  assign opQ       = r_q;
  assign opRamping = r_ramping;
  assign opIdle    = r_idle;

`ifdef MAPPER_STATS_EN
  logic [31:0] r_sym_cnt;
  logic [15:0] r_ovr_cnt;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_sym_cnt <= '0;
      r_ovr_cnt <= '0;
    end else if (ipQAMBlockValid) begin
      r_sym_cnt <= r_sym_cnt + 32'd1;
      if ((r_state == S_RAMP) && (r_ovr_cnt != 16'hFFFF)) begin
        r_ovr_cnt <= r_ovr_cnt + 16'd1;
      end
    end
  end

  assign opSymbolCount  = r_sym_cnt;
  assign opOverrunCount = r_ovr_cnt;
`else
  assign opSymbolCount  = '0;
  assign opOverrunCount = '0;
`endif

endmodule
